bitty_sequencer: RTL and testbench

BITTY_SEQUENCER -- requirements
Module: bitty_sequencer

---
 rtl/bitty_pkg.sv | 24 ++
 rtl/bitty_sequencer_if.sv | 23 ++
 rtl/bitty_sequencer.sv | 158 +++++++++++++++
 tb/tb_bitty_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitty_pkg.sv
// Shared types and constants for the bitty instruction sequencer.
package bitty_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] HALT_OPCODE = 16'hFFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_ISSUE_I,
    ST_ISSUE_S,
    ST_ISSUE_C,
    ST_WAIT_DONE,
    ST_ADVANCE,
    ST_PAUSE,
    ST_HALT
  } state_t;

  function automatic logic is_busy(input state_t s);
    return !(s inside {ST_IDLE, ST_PAUSE, ST_HALT});
  endfunction

endpackage

// File: rtl/bitty_sequencer_if.sv
// Instruction-memory and control-unit handshake between the sequencer and its neighbours.
interface bitty_sequencer_if #(parameter int ADDR_W = 8);
  import bitty_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instruction;
  logic               en_i;
  logic               en_s;
  logic               en_c;
  logic               cu_done;

  modport master (
    output imem_addr, instruction, en_i, en_s, en_c,
    input  imem_data, cu_done
  );

  modport slave (
    input  imem_addr, instruction, en_i, en_s, en_c,
    output imem_data, cu_done
  );

endinterface

// File: rtl/bitty_sequencer.sv
// Fetch / issue / wait sequencer driving a three-phase control unit from a
// registered-read instruction memory, with a watchdog on the completion wait.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | after reset, waiting for start
// FETCH      | imem_addr = pc presented to memory
// LATCH      | imem_data valid; halt opcode or capture instruction
// ISSUE_I    | en_i pulse (held off by stall)
// ISSUE_S    | en_s pulse (held off by stall)
// ISSUE_C    | en_c pulse (held off by stall), arms watchdog
// WAIT_DONE  | waiting for cu_done, watchdog counting down
// ADVANCE    | pc step or end-of-memory halt
// PAUSE      | single-step stop, start resumes at current pc
// HALT       | program end or timeout, start restarts from pc 0
module bitty_sequencer
  import bitty_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                step_mode,
  input  logic                stall,
  bitty_sequencer_if.master   bus,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                halted,
  output logic                error,
  output logic [15:0]         instr_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] PC_MAX  = '1;
  localparam logic [WD_W-1:0]   WD_LOAD = WD_W'(TIMEOUT - 1);

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic [15:0]        r_count, w_count_nxt;
  logic               r_error, w_error_nxt;
  logic [WD_W-1:0]    r_wd, w_wd_nxt;
  logic               w_en_i, w_en_s, w_en_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_instr <= '0;
      r_count <= '0;
      r_error <= 1'b0;
      r_wd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_count <= w_count_nxt;
      r_error <= w_error_nxt;
      r_wd    <= w_wd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_count_nxt = r_count;
    w_error_nxt = r_error;
    w_wd_nxt    = r_wd;
    w_en_i      = 1'b0;
    w_en_s      = 1'b0;
    w_en_c      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_FETCH;
          w_pc_nxt    = '0;
          w_count_nxt = '0;
        end
      end
      ST_FETCH: w_state_nxt = ST_LATCH;
      ST_LATCH: begin
        if (bus.imem_data == HALT_OPCODE) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_instr_nxt = bus.imem_data;
          w_state_nxt = ST_ISSUE_I;
        end
      end
      ST_ISSUE_I: begin
        if (!stall) begin
          w_en_i      = 1'b1;
          w_state_nxt = ST_ISSUE_S;
        end
      end
      ST_ISSUE_S: begin
        if (!stall) begin
          w_en_s      = 1'b1;
          w_state_nxt = ST_ISSUE_C;
        end
      end
      ST_ISSUE_C: begin
        if (!stall) begin
          w_en_c      = 1'b1;
          w_state_nxt = ST_WAIT_DONE;
          w_wd_nxt    = WD_LOAD;
        end
      end
      // cu_done wins even on the watchdog's terminal cycle
      ST_WAIT_DONE: begin
        if (bus.cu_done) begin
          w_count_nxt = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
          w_state_nxt = ST_ADVANCE;
        end else if (r_wd == '0) begin
          w_error_nxt = 1'b1;
          w_state_nxt = ST_HALT;
        end else begin
          w_wd_nxt = r_wd - 1'b1;
        end
      end
      ST_ADVANCE: begin
        if (r_pc == PC_MAX) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_pc_nxt    = r_pc + 1'b1;
          w_state_nxt = step_mode ? ST_PAUSE : ST_FETCH;
        end
      end
      ST_PAUSE: begin
        if (start) w_state_nxt = ST_FETCH;
      end
      ST_HALT: begin
        if (start) begin
          w_pc_nxt    = '0;
          w_count_nxt = '0;
          w_error_nxt = 1'b0;
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.imem_addr   = r_pc;
  assign bus.instruction = r_instr;
  assign bus.en_i        = w_en_i;
  assign bus.en_s        = w_en_s;
  assign bus.en_c        = w_en_c;

  assign pc          = r_pc;
  assign busy        = is_busy(r_state);
  assign halted      = (r_state == ST_HALT);
  assign error       = r_error;
  assign instr_count = r_count;

endmodule

// File: tb/tb_bitty_sequencer.sv
// Self-checking bench: reset, latency, vector table, step/stall/timeout/reset
// sequences, randomized programs against a program-walk model, and ADDR_W=2.
module tb_bitty_sequencer;
  import bitty_pkg::*;

  localparam int TO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, step_mode, stall;
  logic start2, step2, stall2;
  logic [7:0]  pc1;
  logic [1:0]  pc2;
  logic        busy1, halted1, error1, busy2, halted2, error2;
  logic [15:0] cnt1, cnt2;

  bitty_sequencer_if #(.ADDR_W(8)) if1 ();
  bitty_sequencer_if #(.ADDR_W(2)) if2 ();

  bitty_sequencer #(.ADDR_W(8), .TIMEOUT(TO)) u_dut (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .stall(stall),
    .bus(if1), .pc(pc1), .busy(busy1), .halted(halted1), .error(error1), .instr_count(cnt1)
  );

  bitty_sequencer #(.ADDR_W(2), .TIMEOUT(TO)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .step_mode(step2), .stall(stall2),
    .bus(if2), .pc(pc2), .busy(busy2), .halted(halted2), .error(error2), .instr_count(cnt2)
  );

  // memories and control-unit models
  logic [15:0] rom1 [256];
  logic [15:0] rom2 [4];
  int          lat_arr [256];
  logic        cu_off;
  int          cu_cnt = 0;
  int          cu2_cnt = 0;

  always @(posedge clk) begin
    if1.imem_data <= rom1[if1.imem_addr];
    if2.imem_data <= rom2[if2.imem_addr];
  end

  always @(posedge clk) begin
    if (if1.en_c && !cu_off) cu_cnt <= lat_arr[pc1] - 1;
    else if (cu_cnt > 0)     cu_cnt <= cu_cnt - 1;
    if1.cu_done <= (cu_cnt == 1);
  end

  always @(posedge clk) begin
    if (if2.en_c)         cu2_cnt <= 1;
    else if (cu2_cnt > 0) cu2_cnt <= cu2_cnt - 1;
    if2.cu_done <= (cu2_cnt == 1);
  end

  // enable monitor
  int n_i = 0, n_s = 0, n_c = 0, got_n = 0;
  int onehot_err = 0, order_err = 0, stab_err = 0, mon_phase = 0;
  logic [15:0] last_i = '0;
  logic [15:0] got_arr [1024];

  always @(negedge clk) begin
    if ($countones({if1.en_i, if1.en_s, if1.en_c}) > 1) onehot_err <= onehot_err + 1;
    if (if1.en_i) begin
      n_i <= n_i + 1;
      last_i <= if1.instruction;
      got_arr[got_n[9:0]] <= if1.instruction;
      got_n <= got_n + 1;
      if (mon_phase != 0) order_err <= order_err + 1;
      mon_phase <= 1;
    end
    if (if1.en_s) begin
      n_s <= n_s + 1;
      if (mon_phase != 1) order_err <= order_err + 1;
      if (if1.instruction != last_i) stab_err <= stab_err + 1;
      mon_phase <= 2;
    end
    if (if1.en_c) begin
      n_c <= n_c + 1;
      if (mon_phase != 2) order_err <= order_err + 1;
      if (if1.instruction != last_i) stab_err <= stab_err + 1;
      mon_phase <= 0;
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_en(input bit want_c, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(want_c ? if1.en_c : if1.en_i) && n < budget);
    chk(want_c ? "en_c_seen" : "en_i_seen", want_c ? if1.en_c : if1.en_i, 1);
  endtask

  task automatic wait_cond(input bit for_halt, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(for_halt ? halted1 : !busy1) && n < budget);
    chk(for_halt ? "halt_reached" : "pause_reached", for_halt ? halted1 : !busy1, 1);
  endtask

  // runs from IDLE/HALT to HALT; resumes from PAUSE; optional random stall/start noise
  task automatic run1(input bit rnd, input int budget);
    int n = 0;
    @(negedge clk); start = 1'b1;
    forever begin
      @(negedge clk); n++;
      if (halted1 || n > budget) break;
      if (!busy1) start = 1'b1;
      else        start = rnd ? ($urandom_range(3, 0) == 0) : 1'b0;
      stall = rnd ? ($urandom_range(2, 0) == 0) : 1'b0;
    end
    start = 1'b0;
    stall = 1'b0;
    chk("run_halted", halted1, 1);
  endtask

  // walks the program: halt word, cu timeout or end of address space end it
  task automatic model_run(output int e_pc, output int e_cnt, output int e_err,
                           output logic [15:0] e_q[$]);
    int p = 0;
    e_cnt = 0; e_err = 0; e_q.delete();
    forever begin
      if (rom1[p] == 16'hFFFF) break;
      e_q.push_back(rom1[p]);
      if (lat_arr[p] > TO) begin e_err = 1; break; end
      e_cnt++;
      if (p == 255) break;
      p++;
    end
    e_pc = p;
  endtask

  task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3, input int lat);
    for (int i = 0; i < 256; i++) begin rom1[i] = 16'hFFFF; lat_arr[i] = lat; end
    rom1[0] = w0; rom1[1] = w1; rom1[2] = w2; rom1[3] = w3;
  endtask

  typedef struct {
    logic [15:0] w0, w1, w2;
    int          lat;
    logic [7:0]  e_pc;
    logic [15:0] e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int j_i, j_s, j_c, j_h, ni0, ns0, nc0, s_during;
    logic [15:0] instr_seen;

    vecs[0] = '{16'h2408, 16'hFFFF, 16'hFFFF,  2, 8'd1, 16'd1, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h1234, 16'hFFFF,  2, 8'd0, 16'd0, 1'b0};
    vecs[2] = '{16'h1111, 16'h2222, 16'hFFFF, 15, 8'd2, 16'd2, 1'b0};
    vecs[3] = '{16'h1111, 16'h2222, 16'hFFFF, 16, 8'd0, 16'd0, 1'b1};
    vecs[4] = '{16'h0000, 16'h7FFF, 16'hFFFE,  3, 8'd3, 16'd3, 1'b0};

    reset = 1'b1; start = 1'b0; step_mode = 1'b0; stall = 1'b0; cu_off = 1'b0;
    start2 = 1'b0; step2 = 1'b0; stall2 = 1'b0;
    load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2);
    rom2[0] = 16'h0011; rom2[1] = 16'h0022; rom2[2] = 16'h0033; rom2[3] = 16'h0044;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_halted", halted1, 0);
    chk("rst_pc", pc1, 0);
    chk("rst_count", cnt1, 0);
    chk("rst_error", error1, 0);
    chk("rst_enables", {if1.en_i, if1.en_s, if1.en_c}, 0);
    chk("rst_imem_addr", if1.imem_addr, 0);
    chk("rst_busy2", busy2, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy1, 0);
    chk("idle_halted", halted1, 0);

    // single instruction then halt word: cycle-exact latency
    load_rom(16'h2408, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2);
    ni0 = n_i; ns0 = n_s; nc0 = n_c;
    j_i = 0; j_s = 0; j_c = 0; j_h = 0; instr_seen = '0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (if1.en_i && j_i == 0) begin j_i = j; instr_seen = if1.instruction; end
      if (if1.en_s && j_s == 0) j_s = j;
      if (if1.en_c && j_c == 0) j_c = j;
      if (halted1 && j_h == 0) j_h = j;
    end
    chk("lat_en_i", j_i, 3);
    chk("lat_en_s", j_s, 4);
    chk("lat_en_c", j_c, 5);
    chk("lat_halt", j_h, 11);
    chk("one_instr_word", instr_seen, 16'h2408);
    chk("one_pc", pc1, 1);
    chk("one_count", cnt1, 1);
    chk("one_error", error1, 0);
    chk("one_pulses", {n_i - ni0, n_s - ns0, n_c - nc0}, {32'd1, 32'd1, 32'd1});

    // vector table, each run restarted from HALT
    for (int v = 0; v < 5; v++) begin
      repeat (20) @(negedge clk);
      load_rom(vecs[v].w0, vecs[v].w1, vecs[v].w2, 16'hFFFF, vecs[v].lat);
      run1(1'b0, 500);
      chk($sformatf("vec%0d_pc", v), pc1, vecs[v].e_pc);
      chk($sformatf("vec%0d_count", v), cnt1, vecs[v].e_cnt);
      chk($sformatf("vec%0d_error", v), error1, vecs[v].e_err);
    end

    // single-step through three instructions
    repeat (20) @(negedge clk);
    load_rom(16'h00A1, 16'h00A2, 16'h00A3, 16'hFFFF, 2);
    step_mode = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      pulse_start();
      wait_cond(1'b0, 100);
      chk($sformatf("step%0d_paused", k), halted1, 0);
      chk($sformatf("step%0d_pc", k), pc1, k);
      chk($sformatf("step%0d_count", k), cnt1, k);
    end
    pulse_start();
    wait_cond(1'b1, 100);
    chk("step_end_count", cnt1, 3);
    step_mode = 1'b0;

    // stall held four cycles in ISSUE_S
    load_rom(16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2);
    ni0 = n_i; ns0 = n_s; nc0 = n_c; s_during = 0;
    pulse_start();
    wait_en(1'b0, 20);
    @(posedge clk); #1 stall = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (if1.en_s) s_during++;
      @(posedge clk);
    end
    #1 stall = 1'b0;
    @(negedge clk);
    chk("stall_en_s_during", s_during, 0);
    chk("stall_en_s_release", if1.en_s, 1);
    wait_cond(1'b1, 50);
    chk("stall_pulses", {n_i - ni0, n_s - ns0, n_c - nc0}, {32'd1, 32'd1, 32'd1});
    chk("stall_count", cnt1, 1);

    // watchdog: cu never answers
    load_rom(16'h5555, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2);
    cu_off = 1'b1;
    pulse_start();
    wait_en(1'b1, 20);
    @(posedge clk);
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("wd_not_yet", halted1, 0);
    @(negedge clk);
    chk("wd_halt", halted1, 1);
    chk("wd_error", error1, 1);
    chk("wd_count", cnt1, 0);
    cu_off = 1'b0;

    // reset while waiting on the second instruction
    load_rom(16'h2408, 16'h3333, 16'hFFFF, 16'hFFFF, 2);
    lat_arr[1] = 40;
    pulse_start();
    wait_en(1'b1, 20);
    wait_en(1'b1, 30);
    @(posedge clk); #2;
    chk("pre_rst_pc", pc1, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_pc", pc1, 0);
    chk("mid_rst_count", cnt1, 0);
    chk("mid_rst_instr", if1.instruction, 0);
    chk("mid_rst_flags", {busy1, halted1, error1, if1.en_i, if1.en_s, if1.en_c}, 0);
    chk("mid_rst_imem_addr", if1.imem_addr, 0);
    @(negedge clk); reset = 1'b0;
    repeat (45) @(negedge clk);
    chk("post_rst_idle", {busy1, halted1}, 0);
    load_rom(16'h2408, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2);
    ni0 = got_n;
    run1(1'b0, 200);
    chk("post_rst_word", got_arr[ni0[9:0]], 16'h2408);
    chk("post_rst_pc", pc1, 1);
    chk("post_rst_count", cnt1, 1);

    // randomized programs
    for (int it = 0; it < 12; it++) begin
      int len, e_pc, e_cnt, e_err, base, ng;
      logic [15:0] e_q[$];
      logic [15:0] w;
      repeat (20) @(negedge clk);
      len = $urandom_range(6, 1);
      for (int i = 0; i < 256; i++) begin rom1[i] = 16'hFFFF; lat_arr[i] = 2; end
      for (int i = 0; i < len; i++) begin
        w = 16'($urandom);
        if (w == 16'hFFFF) w = 16'h0000;
        rom1[i] = w;
        lat_arr[i] = ($urandom_range(9, 0) == 0) ? $urandom_range(18, 16) : $urandom_range(10, 2);
      end
      step_mode = ($urandom_range(1, 0) == 1);
      model_run(e_pc, e_cnt, e_err, e_q);
      base = got_n;
      run1(1'b1, 3000);
      @(negedge clk);
      ng = got_n - base;
      chk($sformatf("rnd%0d_pc", it), pc1, e_pc);
      chk($sformatf("rnd%0d_count", it), cnt1, e_cnt);
      chk($sformatf("rnd%0d_error", it), error1, e_err);
      chk($sformatf("rnd%0d_issued", it), ng, e_q.size());
      for (int i = 0; i < e_q.size() && i < ng; i++)
        chk($sformatf("rnd%0d_word%0d", it, i), got_arr[(base + i) % 1024], e_q[i]);
    end
    step_mode = 1'b0;

    chk("enables_onehot", onehot_err, 0);
    chk("enable_order", order_err, 0);
    chk("instr_stable", stab_err, 0);

    // 2-bit address space: four instructions, halt at pc=3 without wrapping
    begin
      int n = 0;
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      do begin @(negedge clk); n++; end while (!halted2 && n < 200);
      chk("aw2_halt", halted2, 1);
      chk("aw2_pc", pc2, 3);
      chk("aw2_count", cnt2, 4);
      chk("aw2_error", error2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
